// File: rtl/lcd_cfah_pkg.sv
// Shared definitions for the CFAH1602 command sequencer.
// Holds the controller state encoding, the HD44780 command bytes, the
// power-up init ROM and the microsecond-to-cycle conversion helper.
package lcd_cfah_pkg;

  typedef enum logic [3:0] {
    S_PWR_WAIT  = 4'd0,
    S_INIT_CMD  = 4'd1,
    S_WAIT_DONE = 4'd2,
    S_DELAY     = 4'd3,
    S_IDLE      = 4'd4,
    S_SET_ADDR  = 4'd5,
    S_WR_CHAR   = 4'd6,
    S_CLEAR     = 4'd7,
    S_BUSY_RD   = 4'd8,
    S_BUSY_WAIT = 4'd9
  } t_lcd_ctrl_state;

  localparam logic [7:0] C_LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] C_LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] C_LCD_CLEAR    = 8'h01;
  localparam logic [7:0] C_LCD_ENTRY    = 8'h06;
  localparam logic [7:0] C_LCD_DDRAM_L0 = 8'h80;
  localparam logic [7:0] C_LCD_DDRAM_L1 = 8'hC0;

  localparam int unsigned C_INIT_LEN = 4;
  localparam logic [7:0] C_INIT_ROM [C_INIT_LEN] = '{
    C_LCD_FUNC_SET, C_LCD_DISP_ON, C_LCD_CLEAR, C_LCD_ENTRY
  };

  // ceil(us * 1000 / clk_ns), never less than one cycle
  function automatic int unsigned us_to_cycles(input int unsigned us,
                                               input int unsigned clk_ns);
    int unsigned cyc;
    cyc = (us * 32'd1000 + clk_ns - 32'd1) / clk_ns;
    if (cyc == 32'd0) cyc = 32'd1;
    return cyc;
  endfunction

endpackage

// File: rtl/lcd_cfah_delay.sv
// Loadable down-counter used for the power-up and post-command waits.
// Ports: clk/rst (sync active-high), i_load/i_value load a cycle count,
// o_expire_c is high during the last counted cycle (count == 1).
module lcd_cfah_delay #(
  parameter int unsigned G_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [G_W-1:0] i_value,
  output logic           o_expire_c
);

  logic [G_W-1:0] cnt_q, cnt_d;

  // load wins; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (i_load)                 cnt_d = i_value;
    else if (cnt_q != '0)       cnt_d = cnt_q - G_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_expire_c = (cnt_q == G_W'(1));

endmodule

// File: rtl/lcd_cfah_ctrl.sv
// CFAH1602 command sequencer feeding lcd_cfah_itf.
// Runs the power-up init sequence, then turns character requests into a
// DDRAM address command plus data write, and services clear requests.
// Ports: clk/rst (sync active-high); i_char_* / o_char_ready user request
// handshake; i_clear clear request; o_init_done init status; o_wdata/o_rs/
// o_rw/o_start drive the interface, i_done/i_rdata come back from it.
// Optional macro LCD_BUSY_POLL_EN: replaces post-command delays with busy
// flag reads (except after the first init command). Default: fixed delays.
module lcd_cfah_ctrl
  import lcd_cfah_pkg::*;
#(
  parameter int unsigned G_CLK_PERIOD_NS  = 20,
  parameter int unsigned G_PWR_UP_WAIT_US = 40000,
  parameter int unsigned G_CMD_WAIT_US    = 40,
  parameter int unsigned G_CLR_WAIT_US    = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_char_valid,
  input  logic [7:0] i_char_data,
  input  logic       i_char_line,
  input  logic [3:0] i_char_col,
  output logic       o_char_ready,
  input  logic       i_clear,
  output logic       o_init_done,
  output logic [7:0] o_wdata,
  output logic       o_rs,
  output logic       o_rw,
  output logic       o_start,
  input  logic       i_done,
  input  logic [7:0] i_rdata
);

  localparam int unsigned PWR_CYC = us_to_cycles(G_PWR_UP_WAIT_US, G_CLK_PERIOD_NS);
  localparam int unsigned CMD_CYC = us_to_cycles(G_CMD_WAIT_US, G_CLK_PERIOD_NS);
  localparam int unsigned CLR_CYC = us_to_cycles(G_CLR_WAIT_US, G_CLK_PERIOD_NS);
  localparam int unsigned MAX_A   = (PWR_CYC > CMD_CYC) ? PWR_CYC : CMD_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > CLR_CYC) ? MAX_A : CLR_CYC;
  localparam int unsigned DLY_W   = $clog2(MAX_CYC + 1);

  t_lcd_ctrl_state state_q, state_d;
  logic [1:0]      init_idx_q, init_idx_d;
  logic [1:0]      init_nxt_c;
  logic            init_done_q, init_done_d;
  logic            pwr_arm_q, pwr_arm_d;
  logic            wr_pend_q, wr_pend_d;
  logic [7:0]      char_q, char_d;
  logic            start_q, start_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            rs_q, rs_d;
  logic            rw_q, rw_d;
  logic            ready_q, ready_d;
  logic            advance_c;
  logic            dly_load_c;
  logic [DLY_W-1:0] dly_val_c;
  logic            dly_expire_c;

`ifndef LCD_BUSY_POLL_EN
  logic unused_rdata;
  assign unused_rdata = ^i_rdata;
`endif

  lcd_cfah_delay #(.G_W(DLY_W)) u_delay (
    .clk        (clk),
    .rst        (rst),
    .i_load     (dly_load_c),
    .i_value    (dly_val_c),
    .o_expire_c (dly_expire_c)
  );

  assign init_nxt_c = init_idx_q + 2'd1;

  // next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    pwr_arm_d   = pwr_arm_q;
    wr_pend_d   = wr_pend_q;
    char_d      = char_q;
    start_d     = 1'b0;
    wdata_d     = wdata_q;
    rs_d        = rs_q;
    rw_d        = rw_q;
    advance_c   = 1'b0;
    dly_load_c  = 1'b0;
    dly_val_c   = '0;

    case (state_q)
      S_PWR_WAIT: begin
        // first cycle arms the counter, then wait for it to run out
        if (!pwr_arm_q) begin
          pwr_arm_d  = 1'b1;
          dly_load_c = 1'b1;
          dly_val_c  = DLY_W'(PWR_CYC);
        end else if (dly_expire_c) begin
          state_d    = S_INIT_CMD;
          init_idx_d = 2'd0;
          start_d    = 1'b1;
          wdata_d    = C_INIT_ROM[0];
          rs_d       = 1'b0;
          rw_d       = 1'b0;
        end
      end

      S_INIT_CMD, S_SET_ADDR, S_WR_CHAR, S_CLEAR: state_d = S_WAIT_DONE;

      S_WAIT_DONE: begin
        if (i_done) begin
`ifdef LCD_BUSY_POLL_EN
          // busy flag is not valid until the function set has executed
          if (!init_done_q && init_idx_q == 2'd0) begin
            state_d    = S_DELAY;
            dly_load_c = 1'b1;
            dly_val_c  = DLY_W'(CMD_CYC);
          end else begin
            state_d = S_BUSY_RD;
            start_d = 1'b1;
            wdata_d = 8'h00;
            rs_d    = 1'b0;
            rw_d    = 1'b1;
          end
`else
          state_d    = S_DELAY;
          dly_load_c = 1'b1;
          dly_val_c  = (wdata_q == C_LCD_CLEAR && !rs_q) ? DLY_W'(CLR_CYC)
                                                         : DLY_W'(CMD_CYC);
`endif
        end
      end

      S_DELAY: begin
        if (dly_expire_c) advance_c = 1'b1;
      end

`ifdef LCD_BUSY_POLL_EN
      S_BUSY_RD: state_d = S_BUSY_WAIT;

      S_BUSY_WAIT: begin
        if (i_done) begin
          if (i_rdata[7]) begin
            state_d = S_BUSY_RD;
            start_d = 1'b1;
          end else begin
            advance_c = 1'b1;
          end
        end
      end
`endif

      S_IDLE: begin
        // clear wins; a simultaneous char request stays pending upstream
        if (i_clear) begin
          state_d = S_CLEAR;
          start_d = 1'b1;
          wdata_d = C_LCD_CLEAR;
          rs_d    = 1'b0;
          rw_d    = 1'b0;
        end else if (i_char_valid) begin
          state_d   = S_SET_ADDR;
          char_d    = i_char_data;
          wr_pend_d = 1'b1;
          start_d   = 1'b1;
          wdata_d   = (i_char_line ? C_LCD_DDRAM_L1 : C_LCD_DDRAM_L0) |
                      {4'h0, i_char_col};
          rs_d      = 1'b0;
          rw_d      = 1'b0;
        end
      end

      default: state_d = S_PWR_WAIT;
    endcase

    // what follows a completed command wait
    if (advance_c) begin
      rw_d = 1'b0;
      if (!init_done_q) begin
        if (init_idx_q == 2'(C_INIT_LEN - 1)) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          init_idx_d = init_nxt_c;
          state_d    = S_INIT_CMD;
          start_d    = 1'b1;
          wdata_d    = C_INIT_ROM[init_nxt_c];
          rs_d       = 1'b0;
        end
      end else if (wr_pend_q) begin
        wr_pend_d = 1'b0;
        state_d   = S_WR_CHAR;
        start_d   = 1'b1;
        wdata_d   = char_q;
        rs_d      = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWR_WAIT;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      pwr_arm_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      char_q      <= 8'h00;
      start_q     <= 1'b0;
      wdata_q     <= 8'h00;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      pwr_arm_q   <= pwr_arm_d;
      wr_pend_q   <= wr_pend_d;
      char_q      <= char_d;
      start_q     <= start_d;
      wdata_q     <= wdata_d;
      rs_q        <= rs_d;
      rw_q        <= rw_d;
      ready_q     <= ready_d;
    end
  end

  assign o_char_ready = ready_q;
  assign o_init_done  = init_done_q;
  assign o_start      = start_q;
  assign o_wdata      = wdata_q;
  assign o_rs         = rs_q;
  assign o_rw         = rw_q;

endmodule

// File: tb/tb_lcd_cfah_ctrl.sv
// Directed self-checking bench for lcd_cfah_ctrl with shortened timing
// (power-up 50 cycles, command 50 cycles, clear 100 cycles) and a
// behavioural interface model returning i_done 5 cycles after o_start.
module tb_lcd_cfah_ctrl;

  typedef struct {
    logic [7:0]  d;
    logic        rs;
    logic        rw;
    int unsigned cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_char_valid;
  logic [7:0] i_char_data;
  logic       i_char_line;
  logic [3:0] i_char_col;
  logic       o_char_ready;
  logic       i_clear;
  logic       o_init_done;
  logic [7:0] o_wdata;
  logic       o_rs;
  logic       o_rw;
  logic       o_start;
  logic       i_done;
  logic [7:0] i_rdata;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned rd_cnt = 0;
  int unsigned busy_total = 0;
  int unsigned busy_used = 0;
  int unsigned dcnt = 0;
  rec_t cmd_q[$];

  lcd_cfah_ctrl #(
    .G_CLK_PERIOD_NS  (20),
    .G_PWR_UP_WAIT_US (1),
    .G_CMD_WAIT_US    (1),
    .G_CLR_WAIT_US    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_char_valid (i_char_valid),
    .i_char_data  (i_char_data),
    .i_char_line  (i_char_line),
    .i_char_col   (i_char_col),
    .o_char_ready (o_char_ready),
    .i_clear      (i_clear),
    .o_init_done  (o_init_done),
    .o_wdata      (o_wdata),
    .o_rs         (o_rs),
    .o_rw         (o_rw),
    .o_start      (o_start),
    .i_done       (i_done),
    .i_rdata      (i_rdata)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // interface model: done pulse 5 cycles after start, busy flag on reads
  always @(posedge clk) begin
    if (rst) begin
      dcnt    <= 0;
      i_done  <= 1'b0;
      i_rdata <= 8'h00;
    end else begin
      i_done <= (dcnt == 1);
      if (o_start) dcnt <= 5;
      else if (dcnt != 0) dcnt <= dcnt - 1;
      if (o_start && o_rw) begin
        i_rdata   <= (busy_used < busy_total) ? 8'h80 : 8'h00;
        busy_used <= busy_used + 1;
      end
    end
  end

  // command log: every start pulse, with the cycle it was first visible in
  always @(posedge clk) begin
    if (!rst && o_start) begin
      if (o_rw) rd_cnt = rd_cnt + 1;
      else cmd_q.push_back('{d: o_wdata, rs: o_rs, rw: o_rw, cyc: cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cmd(input string tag, output rec_t r);
    int n = 0;
    while (cmd_q.size() == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_q.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      r = '{d: 8'hxx, rs: 1'bx, rw: 1'bx, cyc: 0};
    end else begin
      r = cmd_q.pop_front();
    end
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] d, input logic rs, output rec_t r);
    wait_cmd(tag, r);
    chk({tag, "_data"}, 32'(r.d), 32'(d));
    chk({tag, "_rs"}, 32'(r.rs), 32'(rs));
    chk({tag, "_rw"}, 32'(r.rw), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (o_char_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(o_char_ready), 32'd1);
  endtask

  // holds i_char_valid until the DUT takes it; returns the accept cycle
  task automatic accept_char(input string tag, output int unsigned acc);
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    i_char_valid = 1'b0;
  endtask

  task automatic check_init(input string tag, input int unsigned rel);
    rec_t r;
    int unsigned clr_cyc;
    int n = 0;
    check_cmd({tag, "_fset"}, 8'h38, 1'b0, r);
    chk({tag, "_pwr_gap"}, 32'(r.cyc - rel >= 50), 32'd1);
    check_cmd({tag, "_dispon"}, 8'h0C, 1'b0, r);
    check_cmd({tag, "_clear"}, 8'h01, 1'b0, r);
    clr_cyc = r.cyc;
    check_cmd({tag, "_entry"}, 8'h06, 1'b0, r);
`ifndef LCD_BUSY_POLL_EN
    chk({tag, "_clr_gap"}, 32'(r.cyc - clr_cyc >= 100), 32'd1);
`endif
    while (o_init_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_init_done"}, 32'(o_init_done), 32'd1);
    chk({tag, "_ready"}, 32'(o_char_ready), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_start"}, 32'(o_start), 32'd0);
    chk({tag, "_ready"}, 32'(o_char_ready), 32'd0);
    chk({tag, "_init_done"}, 32'(o_init_done), 32'd0);
    chk({tag, "_wdata"}, 32'(o_wdata), 32'h00);
    chk({tag, "_rs"}, 32'(o_rs), 32'd0);
    chk({tag, "_rw"}, 32'(o_rw), 32'd0);
  endtask

  initial begin
    rec_t r;
    int unsigned acc;
    int unsigned clr_cyc;
    int unsigned rd0;
    rst = 1'b1;
    i_char_valid = 1'b0;
    i_char_data = 8'h00;
    i_char_line = 1'b0;
    i_char_col = 4'h0;
    i_clear = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst = 1'b0;
    check_init("init", cyc);

    // character write: line 1, column 5, 'A'
    i_char_valid = 1'b1;
    i_char_line = 1'b1;
    i_char_col = 4'd5;
    i_char_data = 8'h41;
    accept_char("wr", acc);
    chk("wr_ready_low", 32'(o_char_ready), 32'd0);
    i_clear = 1'b1;                 // dropped: controller is busy
    @(negedge clk);
    i_clear = 1'b0;
    check_cmd("wr_addr", 8'hC5, 1'b0, r);
    chk("wr_latency", r.cyc, acc);
    chk("wr_busy_ready", 32'(o_char_ready), 32'd0);
    check_cmd("wr_data", 8'h41, 1'b1, r);
    wait_ready("wr_done");
    repeat (20) @(negedge clk);
    chk("busy_clear_dropped", 32'(cmd_q.size()), 32'd0);

    // clear and char in the same cycle: clear first, char afterwards
    i_clear = 1'b1;
    i_char_valid = 1'b1;
    i_char_line = 1'b0;
    i_char_col = 4'd3;
    i_char_data = 8'h5A;
    @(negedge clk);
    i_clear = 1'b0;
    chk("sim_ready_low", 32'(o_char_ready), 32'd0);
    accept_char("sim", acc);
    check_cmd("sim_clear", 8'h01, 1'b0, r);
    clr_cyc = r.cyc;
    check_cmd("sim_addr", 8'h83, 1'b0, r);
`ifndef LCD_BUSY_POLL_EN
    chk("sim_clr_gap", 32'(r.cyc - clr_cyc >= 100), 32'd1);
`endif
    check_cmd("sim_data", 8'h5A, 1'b1, r);
    wait_ready("sim_done");

`ifdef LCD_BUSY_POLL_EN
    // busy flag reported twice before the data write may go
    busy_total = busy_used + 2;
    i_char_valid = 1'b1;
    i_char_line = 1'b1;
    i_char_col = 4'd0;
    i_char_data = 8'h30;
    accept_char("poll", acc);
    check_cmd("poll_addr", 8'hC0, 1'b0, r);
    rd0 = rd_cnt;
    check_cmd("poll_data", 8'h30, 1'b1, r);
    chk("poll_reads", rd_cnt - rd0, 32'd3);
    wait_ready("poll_done");
`else
    rd0 = rd_cnt;
    chk("no_reads", rd0, 32'd0);
`endif

    // reset while waiting for the interface to finish (column 15 boundary)
    i_char_valid = 1'b1;
    i_char_line = 1'b0;
    i_char_col = 4'd15;
    i_char_data = 8'h7E;
    accept_char("mid", acc);
    check_cmd("mid_addr", 8'h8F, 1'b0, r);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("mid_rst");
    @(negedge clk);
    cmd_q.delete();
    rst = 1'b0;
    check_init("reinit", cyc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_cfah_ctrl.md
Name: lcd_cfah_ctrl

Overview:
- Command sequencer directly upstream of lcd_cfah_itf. It drives that interface's i_wdata/i_rs/i_rw/i_start and consumes its o_done.
- Performs the CFAH1602 (HD44780-compatible) power-up init sequence, then accepts single-character write requests and clear-screen requests from user logic.
- Converts each character request into a "set DDRAM address" command followed by a data write.
- Meets the LCD execution times using fixed delay counters, or busy-flag polling when the optional feature is compiled in.

Parameters:
- G_CLK_PERIOD_NS, 20, system clock period in ns; all delays are derived as ceil(time_ns / G_CLK_PERIOD_NS) cycles.
- G_PWR_UP_WAIT_US, 40000, wait after reset before the first command.
- G_CMD_WAIT_US, 40, post-command delay for ordinary commands and data writes.
- G_CLR_WAIT_US, 1600, post-command delay for clear (0x01).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- i_char_valid, in, 1, character write request.
- i_char_data, in, 8, character code.
- i_char_line, in, 1, 0 = line 1, 1 = line 2.
- i_char_col, in, 4, column 0..15.
- o_char_ready, out, 1, request accepted when high together with i_char_valid.
- i_clear, in, 1, single-cycle clear-screen request.
- o_init_done, out, 1, high once the init sequence has completed; stays high until reset.
- o_wdata, out, 8, byte to lcd_cfah_itf i_wdata.
- o_rs, out, 1, to lcd_cfah_itf i_rs.
- o_rw, out, 1, to lcd_cfah_itf i_rw.
- o_start, out, 1, one-cycle transfer start to lcd_cfah_itf i_start.
- i_done, in, 1, one-cycle completion from lcd_cfah_itf o_done.
- i_rdata, in, 8, read data from lcd_cfah_itf o_lcd_rdata; used only when LCD_BUSY_POLL_EN is defined.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Values while rst is high: o_char_ready=0, o_init_done=0, o_start=0, o_wdata=0x00, o_rs=0, o_rw=0, state=S_PWR_WAIT, delay counter=0.
- Reset mid-operation: abort immediately; no further o_start is issued and the FSM restarts from S_PWR_WAIT.
- States:
  - S_PWR_WAIT: count the power-up cycles, then go to S_INIT_CMD with init index 0.
  - S_INIT_CMD: drive the init ROM entry with rs=0, rw=0; pulse o_start for 1 cycle; go to S_WAIT_DONE.
  - S_WAIT_DONE: hold o_wdata/o_rs/o_rw stable until i_done=1, then go to S_DELAY.
  - S_DELAY: count G_CLR_WAIT_US if the last command was 0x01, otherwise G_CMD_WAIT_US. Then:
    - during init, the next ROM entry;
    - after the last ROM entry, set o_init_done=1 and go to S_IDLE;
    - a pending S_WR_CHAR step, if the address command was just sent;
    - otherwise S_IDLE.
  - S_IDLE: o_char_ready=1 only in this state.
  - S_SET_ADDR: issue 0x80|col for line 0 or 0xC0|col for line 1 (rs=0).
  - S_WR_CHAR: issue the latched character with rs=1, rw=0.
  - S_CLEAR: issue 0x01.
- Init ROM (in order): 0x38, 0x0C, 0x01, 0x06.
- Transitions out of S_IDLE:
  - i_clear has priority over i_char_valid in the same cycle: go to S_CLEAR. The char request stays pending because ready is deasserted next cycle.
  - i_char_valid: latch data/line/col, go to S_SET_ADDR.
- Ignored inputs:
  - i_clear outside S_IDLE is dropped, with no queueing.
  - i_done outside S_WAIT_DONE is ignored.
- Latency: o_start asserts exactly 1 cycle after char acceptance.
- Delay counters: width is $clog2 of the largest delay + 1. A computed delay of 0 cycles is treated as 1.
- i_char_col is used as-is (4 bits); no range check is needed.

Optional Feature:
- Macro LCD_BUSY_POLL_EN.
- Defined: S_DELAY is replaced by S_BUSY_RD.
  - S_BUSY_RD issues a read with rs=0, rw=1, o_wdata=0x00, waits for i_done, and samples i_rdata[7].
  - If i_rdata[7]=1, the read repeats. If i_rdata[7]=0, the FSM proceeds.
  - S_PWR_WAIT and the delays between the first two init commands stay time-based; the busy flag is invalid there.
- Undefined: pure fixed delays; i_rdata is unused and o_rw is always 0.

Decomposition:
- Package lcd_cfah_pkg holds:
  - the state enum t_lcd_ctrl_state;
  - command constants C_LCD_FUNC_SET=0x38, C_LCD_DISP_ON=0x0C, C_LCD_CLEAR=0x01, C_LCD_ENTRY=0x06, C_LCD_DDRAM_L0=0x80, C_LCD_DDRAM_L1=0xC0;
  - the init ROM array;
  - the function us_to_cycles().
- One natural sub-module: lcd_cfah_delay. It is a loadable down-counter with load, value, and expire pulse, shared by the power-up and post-command waits.

Test Plan:
- Shorten timing for simulation: G_PWR_UP_WAIT_US=1, G_CMD_WAIT_US=1, G_CLR_WAIT_US=2, G_CLK_PERIOD_NS=20. Use a behavioural itf model that returns i_done 5 cycles after o_start.
- Init sequence:
  - Stimulus: release rst.
  - Response: no o_start for 50 cycles; then o_start with o_wdata 0x38, 0x0C, 0x01, 0x06 (rs=0, rw=0); the gap after 0x01 is ≥100 cycles; o_init_done rises after the last delay; o_char_ready=1.
- Character write:
  - Stimulus: line=1, col=5, data=0x41.
  - Response: o_start with 0xC5 (rs=0), then after the delay o_start with 0x41 (rs=1); o_char_ready is low throughout, then returns high.
- Simultaneous requests:
  - Stimulus: i_clear and i_char_valid asserted in the same cycle.
  - Response: 0x01 is issued first; the char is accepted only after the clear delay, then 0x80|col and the data follow.
- Reset mid-operation:
  - Stimulus: assert rst while in S_WAIT_DONE.
  - Response: all outputs reach reset values on the next edge; the full init sequence replays.
- Busy polling (LCD_BUSY_POLL_EN defined):
  - Stimulus: model returns i_rdata=0x80 twice, then 0x00.
  - Response: three reads with rw=1; the next command is issued only after the 0x00 read.
